byte_lsu_ctrl: RTL and testbench
================================

Name: byte_lsu_ctrl

Overview:
- Load/store sequencer between the MEM stage and a word-only, big-endian data memory.
- Turns LW/LB/LBU/SW/SB requests into word-aligned memory transactions.
- SB becomes a read-modify-write.
- Byte extraction and merge go through one byte_op instance that this block drives.

Parameters:
- TIMEOUT, 255: maximum cycles to wait for mem_ack before flagging an error; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  3  000 LW, 001 LB, 010 LBU, 011 SW, 100 SB, 101 LH, 110 LHU, 111 SH.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; SB uses [7:0].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores.
- resp_err  out  1  timeout or unsupported op; qualified by resp_valid.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  {addr[31:2], 2'b00}.
- mem_wdata  out  32  write word.
- mem_rdata  in  32  read word, valid with mem_ack.
- mem_ack  in  1  transaction complete.

Behaviour:
- All outputs are registered and are 0 while rst_n is low.
- An asynchronous reset mid-transaction aborts it: state goes to IDLE, mem_req drops immediately, and no resp_valid is produced.
- req_ready is 1 from the first clk edge after reset release and only while in IDLE.
- States are IDLE, RD, WR, RESP.
- IDLE:
  - On req_valid, latch op, addr and wdata, and clear the counter.
  - LW/LB/LBU/SB go to RD.
  - SW goes to WR with mem_wdata = wdata.
  - LH/LHU/SH without the optional feature go straight to RESP with resp_err = 1.
- RD:
  - Drive mem_req = 1, mem_we = 0, with mem_addr aligned.
  - On mem_ack, capture mem_rdata into the word register.
  - Loads go to RESP with the result below.
  - SB drives byte_op with pos = {2'b01, addr[1:0]}, org = mem_rdata, val = wdata[7:0], latches the merged word as mem_wdata, and goes to WR.
- Load results:
  - LW returns the whole word.
  - LB uses pos {2'b10, addr[1:0]}; LBU uses pos {2'b00, addr[1:0]}.
  - Big-endian: addr[1:0] = 00 selects bits [31:24].
- WR: drive mem_req = 1, mem_we = 1. On mem_ack, go to RESP.
- RESP: resp_valid = 1 for exactly one cycle with no backpressure, then return to IDLE. req_ready returns to 1 on the next cycle.
- mem_req stays asserted with stable addr/we/wdata until mem_ack or timeout.
- mem_ack is honoured in the same cycle mem_req is high. mem_ack in IDLE or RESP is ignored.
- Timeout counter:
  - Increments every RD/WR cycle without mem_ack and clears on each RD/WR entry.
  - If it reaches TIMEOUT (with TIMEOUT != 0), drop mem_req and go to RESP with resp_err = 1 and resp_rdata = 0.
  - A timeout in RD for SB skips the write.
- mem_ack arriving in the same cycle the counter reaches TIMEOUT counts as success (ack wins).
- Latency from the accept edge to resp_valid, with zero-wait memory: 2 cycles for LW/LB/LBU/SW, 3 cycles for SB. Each memory wait cycle adds 1.

Optional Feature:
- Macro: LSU_HALF_EN.
- When defined, add halfword ops:
  - LH/LHU select [31:16] when addr[1] = 0, else [15:0]; LH sign-extends, LHU zero-extends.
  - SH does a read-modify-write of the selected half with wdata[15:0].
  - Halfword logic is inline, not via byte_op.
  - addr[0] = 1 is misaligned: go directly to RESP with resp_err = 1, and no mem_req is issued.
- When undefined: LH/LHU/SH return an immediate error response, and no halfword logic is synthesised.

Decomposition:
- Package lsu_pkg holds:
  - op encoding constants (OP_LW..OP_SH);
  - the state encoding (ST_IDLE, ST_RD, ST_WR, ST_RESP);
  - byte_op pos field constants (POS_FETCH_U = 2'b00, POS_MIX = 2'b01, POS_FETCH_S = 2'b10).
- Sub-module: one instance of the existing byte_op, shared by extraction and merge and selected by pos. No other sub-modules.

Test Plan:
- LB at addr 0x0000_0101, mem word 0x1280_34F0, ack after 0 waits -> resp_rdata 0xFFFF_FF80, resp_valid 2 cycles after accept, resp_err 0.
- LBU at addr 0x103 on the same word -> 0x0000_00F0. LW at 0x100 -> 0x1280_34F0.
- SB at addr 0x102, wdata 0xAB, memory word 0x1122_3344 -> one read then one write of 0x1122_AB44 to 0x100, resp_valid 3 cycles after accept.
- SW with mem_ack held low for 3 cycles -> mem_req, mem_addr and mem_wdata stable for 4 cycles, resp_valid on the cycle after ack.
- TIMEOUT = 4, mem_ack never asserted -> mem_req high for 4 cycles, then resp_valid with resp_err = 1 and resp_rdata = 0. For SB, no write is issued.
- rst_n pulsed low while in WR -> mem_req = 0 immediately, no resp_valid, req_ready = 1 on the first edge after release.
- With LSU_HALF_EN: LH at 0x102, word 0x0000_8001 -> 0xFFFF_8001; LH at 0x101 -> resp_err = 1 with no mem_req.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the byte load/store sequencer: request ops, FSM states
// and byte_op position selectors.
package lsu_pkg;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b011;
    localparam logic [2:0] OP_SB  = 3'b100;
    localparam logic [2:0] OP_LH  = 3'b101;
    localparam logic [2:0] OP_LHU = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    localparam logic [1:0] POS_FETCH_U = 2'b00;
    localparam logic [1:0] POS_MIX     = 2'b01;
    localparam logic [1:0] POS_FETCH_S = 2'b10;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/byte_op.sv
// Big-endian byte extract (signed/unsigned) or byte merge on a 32-bit word.
// pos = {mode, byte_index}; byte_index 0 addresses bits [31:24].
module byte_op
    import lsu_pkg::*;
(
    input  logic [3:0]  pos,
    input  logic [31:0] org,
    input  logic [7:0]  val,
    output logic [31:0] res
);

    logic [7:0] sel;

    always_comb begin
        unique case (pos[1:0])
            2'd0:    sel = org[31:24];
            2'd1:    sel = org[23:16];
            2'd2:    sel = org[15:8];
            default: sel = org[7:0];
        endcase
    end

    always_comb begin
        res = org;
        case (pos[3:2])
            POS_FETCH_U: res = {24'h0, sel};
            POS_FETCH_S: res = {{24{sel[7]}}, sel};
            POS_MIX: begin
                unique case (pos[1:0])
                    2'd0:    res = {val, org[23:0]};
                    2'd1:    res = {org[31:24], val, org[15:0]};
                    2'd2:    res = {org[31:16], val, org[7:0]};
                    default: res = {org[31:8], val};
                endcase
            end
            default: res = org;
        endcase
    end

endmodule

// File: rtl/byte_lsu_ctrl.sv
// Load/store sequencer for a word-only big-endian memory; SB is a read-modify-write.
// Optional halfword ops (LH/LHU/SH) are built only when LSU_HALF_EN is defined.
module byte_lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

`ifdef LSU_HALF_EN
    localparam int unsigned WD_W = 16;
`else
    localparam int unsigned WD_W = 8;
`endif

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        boff_q, boff_d;
    logic [WD_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              timeout_hit;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic [3:0]        bop_pos;
    logic [31:0]       bop_res;
    logic [31:0]       ld_result;
    logic [31:0]       merged;
    logic              is_rmw;

    always_comb begin
        bop_pos = {POS_FETCH_U, boff_q};
        if (op_q == OP_SB) begin
            bop_pos = {POS_MIX, boff_q};
        end else if (op_q == OP_LB) begin
            bop_pos = {POS_FETCH_S, boff_q};
        end
    end

    byte_op u_byte_op (
        .pos (bop_pos),
        .org (mem_rdata),
        .val (wdata_q[7:0]),
        .res (bop_res)
    );

`ifdef LSU_HALF_EN
    logic [15:0] half_sel;
    logic [31:0] half_ld;
    logic [31:0] half_mix;

    always_comb begin
        half_sel = boff_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        half_ld  = (op_q == OP_LH) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
        half_mix = boff_q[1] ? {mem_rdata[31:16], wdata_q} : {wdata_q, mem_rdata[15:0]};
    end
`endif

    always_comb begin
        ld_result = 32'h0;
        merged    = bop_res;
        is_rmw    = (op_q == OP_SB);
        case (op_q)
            OP_LW:         ld_result = mem_rdata;
            OP_LB, OP_LBU: ld_result = bop_res;
`ifdef LSU_HALF_EN
            OP_LH, OP_LHU: ld_result = half_ld;
            OP_SH: begin
                merged = half_mix;
                is_rmw = 1'b1;
            end
`endif
            default:       ld_result = 32'h0;
        endcase
    end

    assign cnt_inc     = cnt_q + CNT_W'(1);
    // ack is checked before this, so an ack on the final cycle still wins
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        boff_d       = boff_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d       = req_op;
                    boff_d     = req_addr[1:0];
                    wdata_d    = req_wdata[WD_W-1:0];
                    cnt_d      = '0;
                    mem_addr_d = align_word(req_addr);
                    mem_we_d   = 1'b0;
                    case (req_op)
                        OP_LW, OP_LB, OP_LBU, OP_SB: begin
                            state_d   = ST_RD;
                            mem_req_d = 1'b1;
                        end
                        OP_SW: begin
                            state_d     = ST_WR;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = req_wdata;
                        end
`ifdef LSU_HALF_EN
                        default: begin
                            if (!req_addr[0]) begin
                                state_d   = ST_RD;
                                mem_req_d = 1'b1;
                            end else begin
                                state_d      = ST_RESP;
                                resp_valid_d = 1'b1;
                                resp_err_d   = 1'b1;
                            end
                        end
`else
                        default: begin
                            state_d      = ST_RESP;
                            resp_valid_d = 1'b1;
                            resp_err_d   = 1'b1;
                        end
`endif
                    endcase
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    cnt_d = '0;
                    if (is_rmw) begin
                        state_d     = ST_WR;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = merged;
                    end else begin
                        state_d      = ST_RESP;
                        mem_req_d    = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = ld_result;
                    end
                end else if (timeout_hit) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WR: begin
                if (mem_ack || timeout_hit) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = !mem_ack;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_LW;
            boff_q       <= 2'b00;
            wdata_q      <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            boff_q       <= boff_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_byte_lsu_ctrl.sv
// Bench for byte_lsu_ctrl: directed cases then random requests against a word-array model,
// with a memory responder that inserts wait states or withholds ack.
module tb_byte_lsu_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    byte_lsu_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    int checks = 0;
    int failures = 0;

    // Memory environment: ref_mem is the model image, mem is what the DUT sees and writes.
    logic [31:0] ref_mem [16];
    logic [31:0] mem [16];
    logic        load_mem = 1'b0;
    int unsigned cur_waits = 0;
    bit          no_ack = 1'b0;
    logic [31:0] exp_maddr = 32'h0;
    int unsigned wcnt = 0;
    int unsigned n_rd = 0, n_wr = 0, req_cycles = 0, unstable = 0, bad_addr = 0;
    logic        hold = 1'b0;
    logic [64:0] saved = '0;

    assign mem_rdata = mem[mem_addr[5:2]];
    assign mem_ack   = mem_req && !no_ack && (wcnt >= cur_waits);

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
        end else if (mem_req && mem_ack && mem_we) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
        if (mem_req && mem_ack) begin
            if (mem_we) n_wr <= n_wr + 1;
            else        n_rd <= n_rd + 1;
        end
        if (mem_req) req_cycles <= req_cycles + 1;
        if (mem_req && mem_addr !== exp_maddr) bad_addr <= bad_addr + 1;
        if (hold && mem_req && saved !== {mem_we, mem_addr, mem_wdata}) unstable <= unstable + 1;
        wcnt  <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
        hold  <= mem_req && !mem_ack;
        saved <= {mem_we, mem_addr, mem_wdata};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_mem();
        load_mem = 1'b1;
        @(posedge clk);
        #1 load_mem = 1'b0;
    endtask

    // One request; expectations come from byte/halfword arithmetic on the model image.
    task automatic run(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input int unsigned waits, input bit noack);
        logic [31:0] w, exp_r, neww;
        logic [7:0]  bv;
        logic [15:0] hv;
        int unsigned idx, sh, hs, exp_lat, exp_rd, exp_wr, exp_rc, n, k;
        int unsigned rd0, wr0, rc0;
        bit          exp_err, half_en, is_half;
`ifdef LSU_HALF_EN
        half_en = 1'b1;
`else
        half_en = 1'b0;
`endif
        idx  = int'(addr[5:2]);
        w    = ref_mem[idx];
        sh   = (3 - int'(addr[1:0])) * 8;
        bv   = 8'((w >> sh) & 32'hFF);
        hs   = addr[1] ? 0 : 16;
        hv   = 16'((w >> hs) & 32'hFFFF);
        neww = w;
        exp_r = 32'h0; exp_err = 1'b0; exp_rd = 0; exp_wr = 0;
        is_half = (op >= 3'd5);
        if (is_half && (!half_en || addr[0])) begin
            exp_err = 1'b1; exp_lat = 1; exp_rc = 0;
        end else if (noack) begin
            exp_err = 1'b1; exp_lat = TO + 1; exp_rc = TO;
        end else begin
            case (op)
                3'd0: begin exp_r = w; exp_rd = 1; end
                3'd1: begin exp_r = (bv >= 8'd128) ? (32'hFFFF_FF00 | 32'(bv)) : 32'(bv); exp_rd = 1; end
                3'd2: begin exp_r = 32'(bv); exp_rd = 1; end
                3'd3: begin neww = wdata; exp_wr = 1; end
                3'd4: begin
                    neww = (w & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
                    exp_rd = 1; exp_wr = 1;
                end
                3'd5: begin exp_r = hv[15] ? (32'hFFFF_0000 | 32'(hv)) : 32'(hv); exp_rd = 1; end
                3'd6: begin exp_r = 32'(hv); exp_rd = 1; end
                default: begin
                    neww = (w & ~(32'hFFFF << hs)) | ((wdata & 32'hFFFF) << hs);
                    exp_rd = 1; exp_wr = 1;
                end
            endcase
            exp_lat = 1 + exp_rd + exp_wr + waits * (exp_rd + exp_wr);
            exp_rc  = (1 + waits) * (exp_rd + exp_wr);
        end

        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_before", 32'(req_ready), 32'd1);
        rd0 = n_rd; wr0 = n_wr; rc0 = req_cycles;
        exp_maddr = {addr[31:2], 2'b00};
        cur_waits = waits; no_ack = noack;
        req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (resp_valid) break;
        end
        chk("latency", n, exp_lat);
        chk("resp_rdata", resp_rdata, exp_r);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("mem_reads", n_rd - rd0, exp_rd);
        chk("mem_writes", n_wr - wr0, exp_wr);
        chk("mem_req_cycles", req_cycles - rc0, exp_rc);
        ref_mem[idx] = neww;
        chk("mem_word", mem[idx], neww);
        chk("stable", unstable, 0);
        chk("mem_addr", bad_addr, 0);
        @(negedge clk);
        chk("resp_pulse", 32'(resp_valid), 32'd0);
        chk("req_ready_after", 32'(req_ready), 32'd1);
        no_ack = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        repeat (2) @(negedge clk);
        push_mem();
        @(negedge clk);
        chk("reset_outputs", {req_ready, resp_valid, resp_err, mem_req, mem_we,
                              resp_rdata[26:0]} | resp_rdata | mem_addr | mem_wdata, 32'h0);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 chk("ready_first_edge", 32'(req_ready), 32'd1);
        @(negedge clk);

        ref_mem[0] = 32'h1280_34F0;
        push_mem();
        @(negedge clk);
        run(3'd1, 32'h0000_0101, 32'h0, 0, 1'b0);
        run(3'd2, 32'h0000_0103, 32'h0, 0, 1'b0);
        run(3'd0, 32'h0000_0100, 32'h0, 0, 1'b0);
        ref_mem[0] = 32'h1122_3344;
        push_mem();
        @(negedge clk);
        run(3'd4, 32'h0000_0102, 32'h0000_00AB, 0, 1'b0);
        run(3'd3, 32'h0000_0108, 32'hDEAD_BEEF, 3, 1'b0);
        run(3'd4, 32'h0000_0111, 32'h0000_0055, 0, 1'b1);
        run(3'd0, 32'h0000_0114, 32'h0, 0, 1'b1);
        run(3'd3, 32'h0000_0118, 32'h0123_4567, 0, 1'b1);
        ref_mem[0] = 32'h0000_8001;
        push_mem();
        @(negedge clk);
        run(3'd5, 32'h0000_0102, 32'h0, 0, 1'b0);
        run(3'd5, 32'h0000_0101, 32'h0, 0, 1'b0);
        run(3'd7, 32'h0000_0100, 32'h0000_CAFE, 1, 1'b0);

        for (int t = 0; t < 48; t++) begin
            run(3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
        end

        // Async reset while a store waits in WR
        no_ack = 1'b1;
        exp_maddr = 32'h0000_0120;
        req_op = 3'd3; req_addr = 32'h0000_0120; req_wdata = 32'hA5A5_A5A5; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wr_pending", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1 chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        no_ack = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_rst", 32'(req_ready), 32'd1);
        begin
            int unsigned seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (resp_valid || mem_req) seen++;
            end
            chk("no_resp_after_rst", seen, 0);
        end
        chk("mem_after_rst", mem[8], ref_mem[8]);
        run(3'd0, 32'h0000_0120, 32'h0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "bench time limit");
    end

endmodule
